// File: rtl/alu_seq_if.sv
// Operation request/result bundle between control unit and ALU.
// The control unit drives the request side; the ALU returns results and flags.
interface alu_seq_if;
  logic        alu_start;
  logic [3:0]  alu_func;
  logic [1:0]  alu_in_sel;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [7:0]  imm;
  logic [15:0] alu_out;
  logic        alu_end;
  logic        busy;
  logic        flag_z;
  logic        flag_c;
  logic        flag_n;

  modport master (
    output alu_start, alu_func, alu_in_sel,
    output op_a, op_b, imm,
    input  alu_out, alu_end, busy,
    input  flag_z, flag_c, flag_n
  );

  modport slave (
    input  alu_start, alu_func, alu_in_sel,
    input  op_a, op_b, imm,
    output alu_out, alu_end, busy,
    output flag_z, flag_c, flag_n
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential 16-bit ALU: single-cycle ops via CALC,
// shift-add multiply over 16 iterations via MULT.
module alu_seq (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    MULT = 2'd2
  } state_t;

  localparam logic [3:0] F_MUL = 4'b1000;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  func;
  logic [4:0]  cnt;
  logic [31:0] mcand;
  logic [31:0] acc;
  logic [15:0] b_sel;
  logic [16:0] sum;
  logic [15:0] res;
  logic        res_c;
  logic [15:0] fin_out;
  logic        fin_c;
  logic        fin;
  logic        accept;
  logic [15:0] out_q;
  logic        end_q;
  logic        z_q;
  logic        c_q;
  logic        n_q;

  assign accept = (state == IDLE) && bus.alu_start;
  assign fin    = (state == CALC) ||
                  ((state == MULT) && (cnt == 5'd16));

  always_comb begin
    b_sel = 16'h0000;
    case (bus.alu_in_sel)
      2'b00:   b_sel = bus.op_b;
      2'b01:   b_sel = {8'h00, bus.imm};
      2'b10:   b_sel = 16'h0001;
      default: b_sel = 16'h0000;
    endcase
  end

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    res   = 16'h0000;
    res_c = 1'b0;
    case (func)
      4'b0000: {res_c, res} = sum;
      4'b0001: begin
        res   = a - b;
        res_c = (a < b);
      end
      4'b0010: res = a & b;
      4'b0011: res = a | b;
      4'b0100: res = a ^ b;
      4'b0101: res = ~a;
      4'b0110: begin
        res   = {a[14:0], 1'b0};
        res_c = a[15];
      end
      4'b0111: begin
        res   = {1'b0, a[15:1]};
        res_c = a[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    fin_out = res;
    fin_c   = res_c;
    if (state == MULT) begin
      fin_out = acc[15:0];
      fin_c   = |acc[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.alu_start)
          state_nxt = (bus.alu_func == F_MUL) ? MULT : CALC;
      end
      CALC: state_nxt = IDLE;
      MULT: begin
        if (cnt == 5'd16) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a     <= '0;
      b     <= '0;
      func  <= '0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (accept) begin
      a     <= bus.op_a;
      b     <= b_sel;
      func  <= bus.alu_func;
      cnt   <= '0;
      mcand <= {16'h0000, bus.op_a};
      acc   <= '0;
    end else if ((state == MULT) && (cnt != 5'd16)) begin
      // b is consumed LSB-first while the multiplicand walks left
      if (b[0]) acc <= acc + mcand;
      mcand <= {mcand[30:0], 1'b0};
      b     <= {1'b0, b[15:1]};
      cnt   <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      end_q <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      end_q <= fin;
      if (fin) begin
        out_q <= fin_out;
        z_q   <= (fin_out == 16'h0000);
        c_q   <= fin_c;
        n_q   <= fin_out[15];
      end
    end
  end

  assign bus.alu_out = out_q;
  assign bus.alu_end = end_q;
  assign bus.busy    = (state != IDLE);
  assign bus.flag_z  = z_q;
  assign bus.flag_c  = c_q;
  assign bus.flag_n  = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table through a result scoreboard,
// plus busy-start, hold and mid-multiply reset sequences.
module tb_alu_seq;

  logic clk;
  logic rst;
  alu_seq_if bus ();

  alu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  func;
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  imm;
    logic [15:0] out;
    logic        z;
    logic        c;
    logic        n;
    int          poke;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        z;
    logic        c;
    logic        n;
    int          id;
  } exp_t;

  localparam int NV = 16;
  vec_t tbl [NV];
  exp_t q [$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.alu_end) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL stray_end got=1 want=0 t=%0t", $time);
      end else begin
        e = q.pop_front();
        if (bus.alu_out !== e.out || bus.flag_z !== e.z ||
            bus.flag_c !== e.c || bus.flag_n !== e.n) begin
          bad++;
          $display("FAIL result_%0d got=%h z%b c%b n%b want=%h z%b c%b n%b",
                   e.id, bus.alu_out, bus.flag_z, bus.flag_c, bus.flag_n,
                   e.out, e.z, e.c, e.n);
        end
      end
    end
  end

  task automatic set_vec(input int i, input logic [3:0] f,
                         input logic [1:0] s, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] imm,
                         input logic [15:0] o, input logic z,
                         input logic c, input logic n, input int poke);
    tbl[i].func = f;   tbl[i].sel = s;
    tbl[i].a = a;      tbl[i].b = b;
    tbl[i].imm = imm;  tbl[i].out = o;
    tbl[i].z = z;      tbl[i].c = c;
    tbl[i].n = n;      tbl[i].poke = poke;
  endtask

  // Called just after a clock edge; start is sampled at the next edge.
  task automatic run_op(input int id, input vec_t v);
    exp_t e;
    int k;
    int lat;
    bit ended;
    lat = (v.func == 4'b1000) ? 17 : 1;
    e.out = v.out; e.z = v.z; e.c = v.c; e.n = v.n; e.id = id;
    q.push_back(e);
    bus.alu_func = v.func;
    bus.alu_in_sel = v.sel;
    bus.op_a = v.a;
    bus.op_b = v.b;
    bus.imm = v.imm;
    bus.alu_start = 1'b1;
    @(posedge clk);
    #1;
    bus.alu_start = 1'b0;
    bus.op_a = 16'($urandom);
    bus.op_b = 16'($urandom);
    bus.imm = 8'($urandom);
    bus.alu_in_sel = 2'($urandom);
    bus.alu_func = 4'($urandom);
    chk($sformatf("busy_%0d", id), 32'(bus.busy), 32'd1);
    k = 0;
    ended = 0;
    while (!ended && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.alu_end) ended = 1;
      else if (k == v.poke - 1) begin
        bus.alu_func = 4'b0000;
        bus.op_a = 16'h7777;
        bus.alu_start = 1'b1;
      end else if (k == v.poke) bus.alu_start = 1'b0;
    end
    chk($sformatf("latency_%0d", id), 32'(k), 32'(lat));
    chk($sformatf("idle_%0d", id), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vec_t r;
    set_vec(0, 4'h0, 2'b10, 16'hFFFF, 16'h1234, 8'h00, 16'h0000, 1, 1, 0, 0);
    set_vec(1, 4'h1, 2'b00, 16'h0003, 16'h0005, 8'h00, 16'hFFFE, 0, 1, 1, 0);
    set_vec(2, 4'h0, 2'b01, 16'h0005, 16'h9999, 8'hAB, 16'h00B0, 0, 0, 0, 0);
    set_vec(3, 4'h2, 2'b00, 16'hF0F0, 16'hFF00, 8'h00, 16'hF000, 0, 0, 1, 0);
    set_vec(4, 4'h3, 2'b00, 16'h0F00, 16'h00F0, 8'h00, 16'h0FF0, 0, 0, 0, 0);
    set_vec(5, 4'h4, 2'b00, 16'hAAAA, 16'hFFFF, 8'h00, 16'h5555, 0, 0, 0, 0);
    set_vec(6, 4'h5, 2'b00, 16'h00FF, 16'h1111, 8'h00, 16'hFF00, 0, 0, 1, 0);
    set_vec(7, 4'h6, 2'b00, 16'h8001, 16'h0000, 8'h00, 16'h0002, 0, 1, 0, 0);
    set_vec(8, 4'h7, 2'b00, 16'h8001, 16'h0000, 8'h00, 16'h4000, 0, 1, 0, 0);
    set_vec(9, 4'hA, 2'b00, 16'h1234, 16'h5678, 8'h00, 16'h0000, 1, 0, 0, 0);
    set_vec(10, 4'h1, 2'b00, 16'h0005, 16'h0005, 8'h00, 16'h0000, 1, 0, 0, 0);
    set_vec(11, 4'h1, 2'b11, 16'h0005, 16'h0009, 8'h00, 16'h0005, 0, 0, 0, 0);
    set_vec(12, 4'h8, 2'b00, 16'h0123, 16'h0010, 8'h00, 16'h1230, 0, 0, 0, 5);
    set_vec(13, 4'h8, 2'b00, 16'h1000, 16'h0010, 8'h00, 16'h0000, 1, 1, 0, 0);
    set_vec(14, 4'h8, 2'b00, 16'hFFFF, 16'hFFFF, 8'h00, 16'h0001, 0, 1, 0, 0);
    set_vec(15, 4'h8, 2'b01, 16'h0007, 16'hFFFF, 8'h03, 16'h0015, 0, 0, 0, 0);

    bus.alu_start = 1'b0;
    bus.alu_func = '0;
    bus.alu_in_sel = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.imm = '0;
    rst = 1'b0;
    #12;
    chk("rst_out", 32'(bus.alu_out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_end", 32'(bus.alu_end), 32'h0);
    chk("rst_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_n}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // consecutive ops: each start lands in the cycle alu_end is high
    for (int i = 0; i < NV; i++) run_op(i, tbl[i]);

    repeat (3) @(posedge clk);
    #1;
    chk("hold_out", 32'(bus.alu_out), 32'(tbl[NV-1].out));
    chk("hold_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_n}),
        32'({tbl[NV-1].z, tbl[NV-1].c, tbl[NV-1].n}));

    // abort a multiply in its eighth iteration
    bus.alu_func = 4'b1000;
    bus.alu_in_sel = 2'b00;
    bus.op_a = 16'h00FF;
    bus.op_b = 16'h00FF;
    bus.alu_start = 1'b1;
    @(posedge clk);
    #1;
    bus.alu_start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_out", 32'(bus.alu_out), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_end", 32'(bus.alu_end), 32'h0);
    chk("abort_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_n}), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_abort_end", 32'(bus.alu_end), 32'h0);
    chk("post_abort_busy", 32'(bus.busy), 32'h0);

    r = tbl[2];
    r.a = 16'h1000;
    r.imm = 8'h01;
    r.out = 16'h1001;
    run_op(100, r);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
